shim_eject_pad_filter: RTL and testbench

- Sits directly downstream of the SiliconSwitch shim's user receive port (usr_ifc_out / usr_wren_out / usr_full_in).
- Strips the pad phits the injection side inserts to round a packet up to a whole flit.
- Buffers the retained phits in a small show-ahead FIFO and delivers only real user phits to the client.
- Provides the full signal that the shim's ejection FIFO honours combinationally.

---
 rtl/shim_eject_pad_filter.sv | 201 ++++++++++++++++++++
 tb/tb_shim_eject_pad_filter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shim_eject_pad_filter.sv
// Ejection-side pad filter for the SiliconSwitch shim user port.
// Drops flit-rounding pad phits and queues real phits for the client.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   in_ifc / in_wren   phit from the shim and its valid strobe
//   in_full            back-pressure to the shim (one-entry slack)
//   out_ifc / out_wren head-of-FIFO phit and its transfer strobe
//   out_full           client back-pressure
//   pad_drop_cnt       saturating count of discarded pad phits
//   orphan_err         sticky: non-first phit seen while idle
//   pad_err            sticky pad-content error (SN_PAD_CHECK_EN),
//                      otherwise tied to 0
//
// Optional macro: SN_PAD_CHECK_EN enables pad content checking.

package sn_pkg;

    localparam int SN_PHIT_WIDTH = 128;

    typedef struct packed {
        logic                     first;
        logic                     last;
        logic [7:0]               dst_port;
        logic [SN_PHIT_WIDTH-1:0] data;
    } SwitchInterface;

endpackage

module shim_eject_pad_filter
    import sn_pkg::*;
#(
    parameter int FLIT_WIDTH = 512,
    parameter int PHIT_WIDTH = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [$bits(SwitchInterface)-1:0] in_ifc,
    input  logic                             in_wren,
    output logic                             in_full,
    output logic [$bits(SwitchInterface)-1:0] out_ifc,
    output logic                             out_wren,
    input  logic                             out_full,
    output logic [15:0]                      pad_drop_cnt,
    output logic                             orphan_err,
    output logic                             pad_err
);

    localparam int PPF   = FLIT_WIDTH / PHIT_WIDTH;
    localparam int PCW   = $clog2(PPF);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int IFC_W = $bits(SwitchInterface);

    typedef enum logic [1:0] {
        kIdle,
        kBusy,
        kDrop
    } state_t;

    SwitchInterface in_phit;
    assign in_phit = in_ifc;

    state_t         state;
    state_t         state_nx;
    logic [PCW-1:0] phit_count;
    logic [PCW-1:0] count_nx;
    logic           keep;
    logic           drop_pad;
    logic           orphan;

    always_comb begin
        state_nx = state;
        count_nx = phit_count;
        keep     = 1'b0;
        drop_pad = 1'b0;
        orphan   = 1'b0;
        if (in_wren) begin
            unique case (state)
                kIdle: begin
                    if (in_phit.first) begin
                        keep     = 1'b1;
                        count_nx = phit_count + PCW'(1);
                        state_nx = in_phit.last ? kDrop : kBusy;
                    end else begin
                        orphan = 1'b1;
                    end
                end
                kBusy: begin
                    keep     = 1'b1;
                    count_nx = phit_count + PCW'(1);
                    if (in_phit.last) begin
                        state_nx = (count_nx == '0) ? kIdle : kDrop;
                    end
                end
                kDrop: begin
                    drop_pad = 1'b1;
                    count_nx = phit_count + PCW'(1);
                    if (count_nx == '0) begin
                        state_nx = kIdle;
                    end
                end
                default: state_nx = kIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= kIdle;
            phit_count   <= '0;
            pad_drop_cnt <= '0;
            orphan_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            phit_count <= count_nx;
            orphan_err <= orphan_err | orphan;
            if (drop_pad && pad_drop_cnt != 16'hFFFF) begin
                pad_drop_cnt <= pad_drop_cnt + 16'd1;
            end
        end
    end

    // Show-ahead FIFO: head entry is always presented on out_ifc.
    logic [IFC_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    assign fifo_full  = (occ == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (occ == '0);
    // A push into a full FIFO is a protocol violation; it is discarded.
    assign push       = keep & ~fifo_full;
    assign pop        = ~fifo_empty & ~out_full;
    assign out_wren   = pop;
    assign out_ifc    = mem[rd_ptr];
    assign in_full    = (occ >= (AW+1)'(FIFO_DEPTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                occ <= occ + (AW+1)'(1);
            end else if (pop && !push) begin
                occ <= occ - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_ifc;
        end
    end

    no_overflow: assert property (
        @(posedge clk) disable iff (!reset_n) !(keep && fifo_full)
    );

`ifdef SN_PAD_CHECK_EN
    localparam logic [PHIT_WIDTH-1:0] PAD_DATA = {PHIT_WIDTH/2{2'b10}};

    logic [7:0] pkt_dst;
    logic       pad_bad;

    assign pad_bad = (in_phit.data != PAD_DATA) | in_phit.first
                   | in_phit.last | (in_phit.dst_port != pkt_dst);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_dst <= '0;
            pad_err <= 1'b0;
        end else begin
            if (keep && state == kIdle) begin
                pkt_dst <= in_phit.dst_port;
            end
            if (drop_pad && pad_bad) begin
                pad_err <= 1'b1;
            end
        end
    end
`else
    logic unused_pad_fields;
    assign unused_pad_fields = ^{in_phit.dst_port, in_phit.data};
    assign pad_err = 1'b0;
`endif

endmodule

// File: tb/tb_shim_eject_pad_filter.sv
// Self-checking bench for shim_eject_pad_filter.
// Directed scenarios followed by randomized packet traffic.

module tb_shim_eject_pad_filter;
    import sn_pkg::*;

    localparam int PPF   = 4;
    localparam int IFC_W = $bits(SwitchInterface);
    localparam logic [127:0] PAD = {64{2'b10}};

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [IFC_W-1:0] in_ifc = '0;
    logic             in_wren = 1'b0;
    logic             in_full;
    logic [IFC_W-1:0] out_ifc;
    logic             out_wren;
    logic             out_full = 1'b0;
    logic [15:0]      pad_drop_cnt;
    logic             orphan_err;
    logic             pad_err;

    shim_eject_pad_filter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_ifc       (in_ifc),
        .in_wren      (in_wren),
        .in_full      (in_full),
        .out_ifc      (out_ifc),
        .out_wren     (out_wren),
        .out_full     (out_full),
        .pad_drop_cnt (pad_drop_cnt),
        .orphan_err   (orphan_err),
        .pad_err      (pad_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: packet-level bookkeeping.
    SwitchInterface q[$];
    int   pend_pads = 0;
    bit   in_pkt = 0;
    int   pkt_len = 0;
    int   exp_pads = 0;
    bit   exp_orphan = 0;
    bit   exp_pad_err = 0;
    logic [7:0] pkt_dst = '0;
    int   owcnt = 0;

    task automatic chk(string tag, logic [IFC_W-1:0] obs,
                       logic [IFC_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pend_pads = 0;
        in_pkt = 0;
        pkt_len = 0;
        exp_pads = 0;
        exp_orphan = 0;
        exp_pad_err = 0;
    endtask

    task automatic model_accept(SwitchInterface p);
        if (pend_pads > 0) begin
            pend_pads--;
            if (exp_pads < 65535) exp_pads++;
`ifdef SN_PAD_CHECK_EN
            if (p.data != PAD || p.first || p.last || p.dst_port != pkt_dst)
                exp_pad_err = 1;
`endif
        end else if (!in_pkt) begin
            if (p.first) begin
                q.push_back(p);
                pkt_dst = p.dst_port;
                pkt_len = 1;
                if (p.last) pend_pads = PPF - 1;
                else in_pkt = 1;
            end else begin
                exp_orphan = 1;
            end
        end else begin
            q.push_back(p);
            pkt_len++;
            if (p.last) begin
                in_pkt = 0;
                pend_pads = (PPF - pkt_len % PPF) % PPF;
            end
        end
    endtask

    task automatic step(input bit wr, input SwitchInterface p,
                        input bit ofull, output bit acc);
        bit exp_ow;
        bit full_now;
        @(negedge clk);
        out_full = ofull;
        #1;
        full_now = (q.size() >= 3);
        exp_ow = (q.size() != 0) && !ofull;
        chk("out_wren", out_wren, exp_ow);
        if (exp_ow) chk("out_ifc", out_ifc, q[0]);
        chk("in_full", in_full, full_now);
        chk("pad_drop_cnt", pad_drop_cnt, exp_pads);
        chk("orphan_err", orphan_err, exp_orphan);
        chk("pad_err", pad_err, exp_pad_err);
        if (exp_ow) begin
            void'(q.pop_front());
            owcnt++;
        end
        acc = 0;
        in_wren = 1'b0;
        if (wr && !full_now) begin
            in_wren = 1'b1;
            in_ifc = p;
            model_accept(p);
            acc = 1;
        end
    endtask

    task automatic idle(input bit ofull);
        SwitchInterface z;
        bit a;
        z = '0;
        step(0, z, ofull, a);
    endtask

    task automatic send(input SwitchInterface p, input int full_pct);
        bit acc;
        int tries;
        acc = 0;
        tries = 0;
        while (!acc) begin
            step(1, p, ($urandom_range(0, 99) < full_pct), acc);
            tries++;
            if (!acc && tries > 60) begin
                n_cmp++;
                n_bad++;
                $error("FAIL send_timeout: observed stalled expected accept");
                break;
            end
        end
    endtask

    function automatic SwitchInterface mk(bit f, bit l, logic [7:0] d,
                                          logic [127:0] data);
        SwitchInterface p;
        p.first = f;
        p.last = l;
        p.dst_port = d;
        p.data = data;
        return p;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_pkt(input int len, input int full_pct);
        logic [7:0] d;
        int pads;
        d = 8'($urandom);
        for (int i = 0; i < len; i++)
            send(mk(i == 0, i == len - 1, d, rnd128()), full_pct);
        pads = (PPF - len % PPF) % PPF;
        for (int i = 0; i < pads; i++)
            send(mk(0, 0, d, PAD), full_pct);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) idle(0);
    endtask

    initial begin
        int ow0;
        logic [7:0] d;

        #12;
        chk("rst_out_wren", out_wren, 0);
        chk("rst_in_full", in_full, 0);
        chk("rst_pad_cnt", pad_drop_cnt, 0);
        chk("rst_orphan", orphan_err, 0);
        chk("rst_pad_err", pad_err, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // 3-phit packet + 1 pad
        send_pkt(3, 0);
        drain();
        chk("t1_pad_cnt", pad_drop_cnt, 1);

        // 4-phit packet, no pad, then another packet right away
        send_pkt(4, 0);
        send_pkt(2, 0);
        drain();

        // 1-phit + 3 pads, back-to-back 5-phit + 3 pads
        send_pkt(1, 0);
        send_pkt(5, 0);
        drain();
        chk("t3_pad_cnt", pad_drop_cnt, 1 + 2 + 6);

        // Back-pressure: fill to 3, then release
        d = 8'h5a;
        send(mk(1, 0, d, rnd128()), 100);
        send(mk(0, 0, d, rnd128()), 100);
        send(mk(0, 0, d, rnd128()), 100);
        idle(1);
        chk("t4_in_full", in_full, 1);
        ow0 = owcnt;
        send(mk(0, 1, d, rnd128()), 0);
        idle(0);
        idle(0);
        chk("t4_streak", owcnt - ow0, 4);
        drain();

        // Orphan in idle, then a normal packet
        send(mk(0, 0, 8'h11, rnd128()), 0);
        idle(0);
        chk("t5_orphan", orphan_err, 1);
        send_pkt(2, 0);
        drain();
        chk("t5_orphan_sticky", orphan_err, 1);

        // Pad with bad data
        d = 8'h33;
        send(mk(1, 0, d, rnd128()), 0);
        send(mk(0, 1, d, rnd128()), 0);
        send(mk(0, 0, d, 128'h0), 0);
        send(mk(0, 0, d, PAD), 0);
        drain();

        // Randomized traffic
        for (int k = 0; k < 30; k++) begin
            send_pkt($urandom_range(1, 9), 30);
            for (int g = $urandom_range(0, 2); g > 0; g--)
                idle($urandom_range(0, 1));
        end
        drain();

        // Asynchronous reset mid-packet
        send(mk(1, 0, 8'h44, rnd128()), 0);
        send(mk(0, 0, 8'h44, rnd128()), 0);
        in_wren = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_wren", out_wren, 0);
        chk("arst_in_full", in_full, 0);
        chk("arst_pad_cnt", pad_drop_cnt, 0);
        chk("arst_orphan", orphan_err, 0);
        chk("arst_pad_err", pad_err, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        send_pkt(3, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
